// File: rtl/sqrt_rr_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 enable decoder among eight
// requesters. These are the square-root approximation stages and the host load port.
// It drives the decoder index/enable and a registered one-hot grant. Every
// release is followed by one idle cycle, and a grant can be held at most
// MAX_HOLD cycles.
module sqrt_rr_arbiter #(
    parameter int MAX_HOLD = 255,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {IDLE, GRANT} state_t;

    // The timeout fires on the edge where the counter reaches MAX_HOLD-1.
    // This gives exactly MAX_HOLD granted cycles, counting the grant cycle itself.
    localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic [7:0]         gnt_q, gnt_d;
    logic               to_q, to_d;

    logic               win_vld;
    logic [2:0]         win_idx;
    logic [2:0]         cand;

    // Find the first requester after the last served index, wrapping 7 -> 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_q + 3'(i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Compute the next state and the next registered outputs.
    // A dropped request is treated like rel. Release takes priority over timeout.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        hold_d   = hold_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        gnt_d    = gnt_q;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d  = GRANT;
                    sel_d    = win_idx;
                    sel_en_d = 1'b1;
                    gnt_d    = 8'b1 << win_idx;
                    hold_d   = '0;
                end else begin
                    sel_en_d = 1'b0;
                    gnt_d    = '0;
                end
            end
            GRANT: begin
                if (rel || !req[sel_q]) begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    gnt_d    = '0;
                    last_d   = sel_q;
                end else if (TIMEOUT_EN && (hold_q == HOLD_LAST)) begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    gnt_d    = '0;
                    last_d   = sel_q;
                    to_d     = 1'b1;
                end else begin
                    hold_d   = hold_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                gnt_d    = '0;
            end
        endcase
    end

    // State and output registers. Reset gives index 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 3'd7;
            hold_q   <= '0;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            gnt_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            gnt_q    <= gnt_d;
            to_q     <= to_d;
        end
    end

    assign sel         = sel_q;
    assign sel_en      = sel_en_q;
    assign gnt         = gnt_q;
    assign busy        = sel_en_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_sqrt_rr_arbiter.sv
// Scoreboard bench for sqrt_rr_arbiter (MAX_HOLD=4): stimulus pushes the
// reference model's expected outputs, a monitor pops and compares each cycle.
module tb_sqrt_rr_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       rel = 1'b0;
    logic [2:0] sel;
    logic       sel_en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout_err;

    sqrt_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .sel(sel), .sel_en(sel_en), .gnt(gnt), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       sel_en;
        logic [7:0] gnt;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    // Reference model: who owns the decoder, how many cycles it has had it,
    // and who was served last.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_last  = 7;
    logic [2:0] m_sel   = '0;
    logic       m_to    = 1'b0;

    function automatic void model_step(input logic r, input logic [7:0] rq, input logic rl);
        if (r) begin
            m_owner = -1; m_held = 0; m_last = 7; m_sel = '0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (m_owner < 0 && rq[c]) begin
                    m_owner = c; m_held = 1; m_sel = 3'(c);
                end
            end
        end else if (rl || !rq[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_to = 1'b0;
        end else if (MAXH != 0 && m_held == MAXH) begin
            m_last = m_owner; m_owner = -1; m_to = 1'b1;
        end else begin
            m_held++; m_to = 1'b0;
        end
    endfunction

    task automatic cyc(input logic r, input logic [7:0] rq, input logic rl);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; rel = rl;
        model_step(r, rq, rl);
        e.sel    = m_sel;
        e.sel_en = (m_owner >= 0);
        e.gnt    = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        e.busy   = (m_owner >= 0);
        e.to     = m_to;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs after each edge against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sel",         {5'b0, sel},         {5'b0, e.sel});
                chk("sel_en",      {7'b0, sel_en},      {7'b0, e.sel_en});
                chk("gnt",         gnt,                 e.gnt);
                chk("busy",        {7'b0, busy},        {7'b0, e.busy});
                chk("timeout_err", {7'b0, timeout_err}, {7'b0, e.to});
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        // reset with all requesting, first grant must be index 0
        cyc(1, 8'hFF, 0); cyc(1, 8'hFF, 0);
        cyc(0, 8'hFF, 0); cyc(0, 8'hFF, 1);
        // single request, rel, then rel while idle
        cyc(1, 8'h00, 0);
        cyc(0, 8'h04, 0); cyc(0, 8'h04, 0); cyc(0, 8'h04, 1);
        cyc(0, 8'h00, 0); cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
        // fairness: full sweep plus wrap back to 0
        cyc(1, 8'h00, 0);
        for (int g = 0; g < 9; g++) begin
            cyc(0, 8'hFF, 0); cyc(0, 8'hFF, 0); cyc(0, 8'hFF, 1);
        end
        // wrap: serve 6, then 0x41 gives 0 then 6
        cyc(1, 8'h00, 0);
        cyc(0, 8'h40, 0); cyc(0, 8'h40, 1);
        cyc(0, 8'h41, 0); cyc(0, 8'h41, 1);
        cyc(0, 8'h41, 0); cyc(0, 8'h41, 1); cyc(0, 8'h00, 0);
        // timeout with no release
        cyc(1, 8'h00, 0);
        for (int i = 0; i < 12; i++) cyc(0, 8'h03, 0);
        // reset mid-grant of index 5, restart from index 0
        cyc(1, 8'h00, 0);
        cyc(0, 8'h20, 0); cyc(0, 8'h20, 0); cyc(1, 8'hFF, 0);
        cyc(0, 8'hFF, 0); cyc(0, 8'hFF, 1);
        // rel coincident with hold limit
        cyc(1, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h01, 0);
        cyc(0, 8'h01, 1); cyc(0, 8'h00, 0);
        // dropped request, other req bits changing during grant
        cyc(0, 8'h02, 0); cyc(0, 8'h06, 0); cyc(0, 8'h05, 0);
        cyc(0, 8'h04, 0); cyc(0, 8'h00, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rq;
            rq = 8'($urandom) & 8'($urandom);
            cyc(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 3) == 0));
        end
        cyc(0, 8'h00, 0);
        stim_done = 1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
